// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter: display reads in active video, queued host ops in blanking
// Optional host reads through the command FIFO: define VGA_ARB_HOST_READ_EN.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int FB_WORDS   = 307200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            de,
  input  logic                            vsync,
  input  logic                            host_valid,
  output logic                            host_ready,
  input  logic [ADDR_W-1:0]               host_addr,
  input  logic [DATA_W-1:0]               host_wdata,
`ifdef VGA_ARB_HOST_READ_EN
  input  logic                            host_we,
  output logic                            host_rvalid,
  output logic [DATA_W-1:0]               host_rdata,
`endif
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic                            pix_de,
  output logic [DATA_W-1:0]               pix_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DISP, HOST} state_t;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [LVL_W-1:0]  wr_ptr_q, rd_ptr_q, level;
  logic              fifo_empty, push, pop, head_we;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic              vsync_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              disp_v2_q, pix_de_q;
  logic [DATA_W-1:0] pix_data_q;

  // Extra pointer bit distinguishes full from empty.
  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (level == '0);
  assign host_ready = ~rst & (level != LVL_W'(FIFO_DEPTH));
  assign push       = host_valid & host_ready;
  assign pop        = (state_d == HOST);

`ifdef VGA_ARB_HOST_READ_EN
  logic              fifo_we_q [FIFO_DEPTH];
  logic              rd_v2_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  assign head_we     = fifo_we_q[rd_ptr_q[PTR_W-1:0]];
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (push) fifo_we_q[wr_ptr_q[PTR_W-1:0]] <= host_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v2_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_v2_q  <= (state_q == HOST) & ~mem_we_q;
      rvalid_q <= rd_v2_q;
      rdata_q  <= rd_v2_q ? mem_rdata : '0;
    end
  end
`else
  assign head_we = 1'b1;
`endif

  always_comb begin
    state_d = IDLE;
    if (de)               state_d = DISP;
    else if (!fifo_empty) state_d = HOST;
  end

  // A vsync falling edge beats the post-DISP increment.
  always_comb begin
    disp_addr_d = disp_addr_q;
    if (vsync_q & ~vsync)
      disp_addr_d = '0;
    else if (de)
      disp_addr_d = (disp_addr_q == ADDR_W'(FB_WORDS - 1)) ? '0 : disp_addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= host_addr;
      fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vsync_q     <= 1'b0;
      disp_addr_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      disp_v2_q   <= 1'b0;
      pix_de_q    <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_q + LVL_W'(push);
      rd_ptr_q    <= rd_ptr_q + LVL_W'(pop);
      vsync_q     <= vsync;
      disp_addr_q <= disp_addr_d;
      case (state_d)
        DISP: begin
          mem_en_q    <= 1'b1;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= disp_addr_q;
          mem_wdata_q <= '0;
        end
        HOST: begin
          mem_en_q    <= 1'b1;
          mem_we_q    <= head_we;
          mem_addr_q  <= fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
          mem_wdata_q <= fifo_data_q[rd_ptr_q[PTR_W-1:0]];
        end
        default: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
      // state_q is the stage-1 valid of the op now on the mem bus.
      disp_v2_q  <= (state_q == DISP);
      pix_de_q   <= disp_v2_q;
      pix_data_q <= disp_v2_q ? mem_rdata : '0;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_de     = pix_de_q;
  assign pix_data   = pix_data_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter with a queue-based reference model
module tb_vga_fb_arbiter;
  localparam int AW = 19, DW = 16, FBW = 1000, DEPTH = 4;

  logic          clk = 1'b0, rst = 1'b1, de = 1'b0, vsync = 1'b1, host_valid = 1'b0;
  logic          host_ready;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
`ifdef VGA_ARB_HOST_READ_EN
  logic          host_we = 1'b1, host_rvalid;
  logic [DW-1:0] host_rdata;
`endif
  logic          mem_en, mem_we, pix_de;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, pix_data;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    fifo_level;

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .de(de), .vsync(vsync),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_wdata(host_wdata),
`ifdef VGA_ARB_HOST_READ_EN
    .host_we(host_we), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_de(pix_de), .pix_data(pix_data), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0, cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a) ^ 16'h5A5A;
  endfunction

  // Synchronous single-port RAM seen by the DUT.
  logic [DW-1:0] bram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= bram.exists(int'(mem_addr)) ? bram[int'(mem_addr)] : init_word(int'(mem_addr));
    end
  end

  // Reference model: per-cycle op choice, expectations scheduled by absolute cycle.
  typedef struct { int addr; int data; bit we; } cmd_t;
  cmd_t          mq[$];
  logic [DW-1:0] mram [int];
  int            disp_m = 0;
  bit            vs_prev = 0, armed = 0;
  int em_tag[8], em_en[8], em_we[8], em_addr[8], em_wd[8], em_chka[8];
  int ep_tag[8], ep_de[8], ep_data[8], er_tag[8], er_v[8], er_d[8];

  initial for (int i = 0; i < 8; i++) begin
    em_tag[i] = -1; ep_tag[i] = -1; er_tag[i] = -1;
  end

  function automatic int mread(input int a);
    return mram.exists(a) ? int'(mram[a]) : int'(init_word(a));
  endfunction

  always @(posedge clk) begin
    int   c, s1, s3;
    bit   push;
    cmd_t h, n;
    c = cyc; s1 = (c + 1) % 8; s3 = (c + 3) % 8;
    if (rst) begin
      mq.delete(); disp_m = 0; vs_prev = 0; armed = 1;
      em_tag[s1] = c + 1; em_en[s1] = 0; em_we[s1] = 0; em_addr[s1] = 0; em_wd[s1] = 0; em_chka[s1] = 1;
      for (int k = 1; k <= 3; k++) begin
        ep_tag[(c+k)%8] = c + k; ep_de[(c+k)%8] = 0; ep_data[(c+k)%8] = 0;
        er_tag[(c+k)%8] = c + k; er_v[(c+k)%8] = 0;
      end
    end else begin
      push = host_valid && (mq.size() < DEPTH);
      em_tag[s1] = c + 1; em_chka[s1] = 0;
      ep_tag[s3] = c + 3; ep_de[s3] = 0; ep_data[s3] = 0;
      er_tag[s3] = c + 3; er_v[s3] = 0;
      if (de) begin
        em_en[s1] = 1; em_we[s1] = 0; em_addr[s1] = disp_m;
        ep_de[s3] = 1; ep_data[s3] = mread(disp_m);
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        em_en[s1] = 1; em_we[s1] = h.we; em_addr[s1] = h.addr; em_wd[s1] = h.data;
        if (h.we) mram[h.addr] = DW'(h.data);
        else begin er_v[s3] = 1; er_d[s3] = mread(h.addr); end
      end else begin
        em_en[s1] = 0; em_we[s1] = 0;
      end
      if (vs_prev && !vsync) disp_m = 0;
      else if (de) disp_m = (disp_m + 1) % FBW;
      vs_prev = vsync;
      if (push) begin
        n.addr = int'(host_addr); n.data = int'(host_wdata);
`ifdef VGA_ARB_HOST_READ_EN
        n.we = host_we;
`else
        n.we = 1'b1;
`endif
        mq.push_back(n);
      end
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin
    int s;
    if (armed) begin
      s = cyc % 8;
      check("host_ready", int'(host_ready), int'(!rst && (mq.size() < DEPTH)));
      check("fifo_level", int'(fifo_level), mq.size());
      if (em_tag[s] == cyc) begin
        check("mem_en", int'(mem_en), em_en[s]);
        check("mem_we", int'(mem_we), em_we[s]);
        if (em_en[s] != 0 || em_chka[s] != 0) check("mem_addr", int'(mem_addr), em_addr[s]);
        if (em_we[s] != 0 || em_chka[s] != 0) check("mem_wdata", int'(mem_wdata), em_wd[s]);
      end
      if (ep_tag[s] == cyc) begin
        check("pix_de", int'(pix_de), ep_de[s]);
        check("pix_data", int'(pix_data), ep_data[s]);
      end
`ifdef VGA_ARB_HOST_READ_EN
      if (er_tag[s] == cyc) begin
        check("host_rvalid", int'(host_rvalid), er_v[s]);
        if (er_v[s] != 0) check("host_rdata", int'(host_rdata), er_d[s]);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input int a, input int d, input bit we);
    bit ok;
    ok = 0;
    host_valid = 1'b1; host_addr = AW'(a); host_wdata = DW'(d);
`ifdef VGA_ARB_HOST_READ_EN
    host_we = we;
`else
    if (!we) check("read without read support", 0, 1);
`endif
    for (int t = 0; t < 100 && !ok; t++) begin
      ok = host_ready;
      tick();
    end
    if (!ok) check("push timeout", 0, 1);
    host_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    tick(); tick();
    check("reset host_ready", int'(host_ready), 0);
    check("reset mem_en", int'(mem_en), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset pix_de", int'(pix_de), 0);
    check("reset fifo_level", int'(fifo_level), 0);
    rst = 1'b0; #1;
    check("ready after reset", int'(host_ready), 1);
    tick();

    // Frame start, then one 640-pixel line.
    vsync = 1'b0; tick(); vsync = 1'b1;
    for (int i = 0; i < 640; i++) begin
      de = 1'b1; tick();
      if (i == 0)   check("first disp addr", int'(mem_addr), 0);
      if (i == 1)   check("pix_de not yet", int'(pix_de), 0);
      if (i == 2)   begin check("pix_de at +3", int'(pix_de), 1); check("pixel 0", int'(pix_data), 16'h5A5A); end
      if (i == 639) check("last disp addr", int'(mem_addr), 639);
    end

    // Four writes queued during active video, drained in blanking.
    for (int k = 0; k < 4; k++) push_cmd(16'h10 + k, 16'hA0A0 + k * 16'h0101, 1'b1);
    check("full ready", int'(host_ready), 0);
    check("full level", int'(fifo_level), 4);
    de = 1'b0;
    repeat (6) tick();
    check("drained level", int'(fifo_level), 0);
    for (int k = 0; k < 4; k++) check("ram after drain", int'(bram[16'h10 + k]), 16'hA0A0 + k * 16'h0101);

    // Full FIFO with alternating de; a fifth command waits for space.
    de = 1'b1;
    for (int k = 0; k < 4; k++) push_cmd(16'h20 + k, 16'hB0B0 + k, 1'b1);
    host_valid = 1'b1; host_addr = AW'(16'h24); host_wdata = 16'hB4B4;
    for (int i = 0; i < 16; i++) begin
      de = (i % 2) != 0;
      ok = host_ready;
      tick();
      if (ok) host_valid = 1'b0;
    end
    de = 1'b0; host_valid = 1'b0;
    repeat (6) tick();
    check("held cmd written", int'(bram[16'h24]), 16'hB4B4);
    check("first toggle write", int'(bram[16'h20]), 16'hB0B0);

    // Address wrap, then a vsync edge in mid-line.
    vsync = 1'b0; tick(); vsync = 1'b1;
    for (int i = 0; i < 1006; i++) begin
      de = 1'b1; tick();
      if (i == 999)  check("addr before wrap", int'(mem_addr), 999);
      if (i == 1000) check("addr after wrap", int'(mem_addr), 0);
    end
    vsync = 1'b0; tick();
    check("addr in edge cycle", int'(mem_addr), 6);
    vsync = 1'b1; tick();
    check("addr after vsync edge", int'(mem_addr), 0);
    tick();
    check("addr continues", int'(mem_addr), 1);

    // Reset while writes are queued and video is active.
    for (int k = 0; k < 3; k++) push_cmd(16'h30 + k, 16'hC0C0 + k, 1'b1);
    rst = 1'b1; tick();
    check("rst level", int'(fifo_level), 0);
    check("rst mem_en", int'(mem_en), 0);
    check("rst pix_de", int'(pix_de), 0);
    rst = 1'b0; de = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 3; k++) check("discarded write", int'(bram.exists(16'h30 + k)), 0);

`ifdef VGA_ARB_HOST_READ_EN
    push_cmd(16'h50, 16'h1234, 1'b1);
    push_cmd(16'h50, 0, 1'b0);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (host_rvalid) ok = 1; else tick();
    end
    check("rvalid seen", int'(ok), 1);
    check("read data", int'(host_rdata), 16'h1234);
    tick();
    check("rvalid one cycle", int'(host_rvalid), 0);
`endif

    repeat (5) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter between the 640x480 display refill path and a host write port. It sits between the VGA timing generator (de/vsync) and one synchronous single-port RAM. The display is never stalled: it owns the memory on every active-video cycle. Host writes are queued in a small FIFO and drained only during blanking.

## Interface
Parameters:
- `ADDR_W`, 19, framebuffer word-address width
- `DATA_W`, 16, pixel/word width
- `FB_WORDS`, 307200, words per frame (640*480); display address wraps here
- `FIFO_DEPTH`, 4, host command FIFO entries (power of two, >=2)

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `de`  in  1  active-video strobe from the timing generator
- `vsync`  in  1  vertical sync, active-low
- `host_valid`  in  1  host command valid
- `host_ready`  out  1  FIFO can accept a command
- `host_addr`  in  ADDR_W  host word address
- `host_wdata`  in  DATA_W  host write data
- `host_we`  in  1  1 = write, 0 = read (only with `VGA_ARB_HOST_READ_EN`)
- `host_rvalid`  out  1  read data valid, one-cycle pulse (only with macro)
- `host_rdata`  out  DATA_W  read data (only with macro)
- `mem_en`  out  1  RAM enable
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid 1 cycle after `mem_en` with `mem_we=0`
- `pix_de`  out  1  `de` delayed 3 cycles
- `pix_data`  out  DATA_W  pixel aligned with `pix_de`; 0 when `pix_de=0`
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Command stage FSM: states `IDLE`, `DISP`, `HOST`, re-evaluated every cycle.
  - `de=1` -> `DISP`: issue a display read at `disp_addr`.
  - `de=0` and FIFO non-empty -> `HOST`: pop the head and issue it.
  - Otherwise -> `IDLE`: `mem_en=0`.
- Priority is strict: display over host. A host op is never issued in a `de=1` cycle.
- `disp_addr`:
  - Cleared to 0 on the cycle after a `vsync` 1->0 edge. The edge is detected against a registered copy of `vsync`.
  - Increments by 1 after each `DISP` cycle.
  - Wraps from FB_WORDS-1 to 0.
  - If an increment and a vsync clear coincide, the clear wins.
- FIFO:
  - `host_ready = ~full`. Push on `host_valid & host_ready`.
  - A push and a pop in the same cycle are both legal; the level is unchanged.
  - When full, `host_ready=0` even if a pop happens that cycle.
  - A command is held until accepted; no overwrite, no drop.
- Writes take effect in RAM in the `HOST` mem cycle. Writes complete in FIFO order.
- Reset:
  - Clears the FIFO, `disp_addr`, the vsync register, all pipeline valids, and the FSM (to `IDLE`).
  - Queued commands are discarded.
  - Reset mid-frame resumes correctly only after the next vsync edge; `disp_addr` restarts at 0 immediately.

## Timing
- Cycle N: command decision. Cycle N+1: `mem_*` driven from registers. Cycle N+2: `mem_rdata` captured into `pix_data`/`host_rdata`. Cycle N+3: outputs visible.
- Display latency: `de` high at N -> `pix_de=1` with that pixel at N+3. The integrator delays hsync/vsync by 3 to match.
- Host write latency: accepted at cycle A -> earliest RAM write at A+2 (one FIFO cycle, one register stage), if `de=0`.
- Reset values:
  - `host_ready=0` during reset, 1 in the first cycle after.
  - `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `pix_de=0`, `pix_data=0`, `fifo_level=0`, `host_rvalid=0`, `host_rdata=0`.
- Throughput: one op per cycle. Host bandwidth is 160 cycles per line in 640x480 timing, plus full lines during vertical blanking.

## Configuration
- `VGA_ARB_HOST_READ_EN` defined:
  - The `host_we`, `host_rvalid` and `host_rdata` ports exist, and FIFO entries store `we`.
  - A read entry issues `mem_en=1`, `mem_we=0`.
  - `host_rvalid` pulses 3 cycles after the pop, with `host_rdata` = RAM contents, in FIFO order.
- Not defined:
  - Those three ports are absent, and every entry is a write.
  - The FIFO carries address and data only.

## Test plan
- Reset, then `de=1` for 640 cycles after a vsync edge -> `mem_addr` 0..639 on consecutive cycles; `pix_de` goes high 3 cycles after `de`.
- Host pushes 4 writes (addr 0x10..0x13, data 0xA0A0..0xA3A3) during `de=1` -> `host_ready=0` after the 4th and `fifo_level=4`. After `de` falls, 4 consecutive `mem_we=1` cycles occur in order and `fifo_level` returns to 0.
- `de` toggles 1/0 every cycle with the FIFO non-empty -> host ops occur only in `de=0` cycles; `disp_addr` advances without gaps.
- 307200 `de` cycles without vsync -> `mem_addr` wraps 307199 -> 0. A vsync falling edge mid-line -> the next `DISP` uses address 0.
- Assert `rst` with 3 entries queued and `de` active -> `fifo_level=0`, `mem_en=0`, `pix_de=0` the next cycle; no queued write ever reaches RAM.
- With `VGA_ARB_HOST_READ_EN`: write 0x1234 to 0x50, then read 0x50 during blanking -> `host_rvalid` 1 cycle, 3 cycles after the pop, `host_rdata=0x1234`.
